// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame states, prefix bytes and the key codes used by game blocks.
package ps2_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  localparam logic [BYTE_W-1:0] PS2_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] PS2_BRK   = 8'hF0;

  localparam logic [BYTE_W-1:0] KEY_1     = 8'h16;
  localparam logic [BYTE_W-1:0] KEY_2     = 8'h1E;
  localparam logic [BYTE_W-1:0] KEY_ESC   = 8'h76;
  localparam logic [BYTE_W-1:0] KEY_ENTER = 8'h5A;
  localparam logic [BYTE_W-1:0] KEY_UP    = 8'h75;
  localparam logic [BYTE_W-1:0] KEY_DOWN  = 8'h72;
  localparam logic [BYTE_W-1:0] KEY_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] KEY_RIGHT = 8'h74;

  // A frame is good when the stop bit is high and data plus parity hold an odd count of ones.
  function automatic logic frame_ok(input logic [BYTE_W-1:0] data,
                                    input logic parity,
                                    input logic stop);
    return stop & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Bundle of the raw PS/2 pins and the decoded key outputs of ps2_keycode_rx.
interface ps2_keycode_rx_if;
  import ps2_pkg::*;

  logic              ps2_clk;
  logic              ps2_data;
  logic [BYTE_W-1:0] key_code;
  logic              key_ext;
  logic              key_valid;
  logic              key_break;
  logic              parity_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output key_code,
    output key_ext,
    output key_valid,
    output key_break,
    output parity_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  key_code,
    input  key_ext,
    input  key_valid,
    input  key_break,
    input  parity_err
  );

endinterface

// File: rtl/ps2_sync.sv
// Two-flop synchronisers for the PS/2 pins plus a falling-edge detector on the clock line.
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic ps2_fall,
  output logic data_sync
);

  logic [1:0] clk_ff;
  logic       clk_dly;
  logic [1:0] data_ff;

  // Reset to the idle-high bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_ff  <= 2'b11;
      clk_dly <= 1'b1;
      data_ff <= 2'b11;
    end else begin
      clk_ff  <= {clk_ff[0], ps2_clk};
      clk_dly <= clk_ff[1];
      data_ff <= {data_ff[0], ps2_data};
    end
  end

  assign ps2_fall  = clk_dly & ~clk_ff[1];
  assign data_sync = data_ff[1];

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: frames bytes, decodes E0/F0 prefixes, holds the pressed key code.
// Optional mid-frame inactivity timeout is enabled with the PS2_TIMEOUT_EN macro.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic               clk,
  input logic               rst_n,
  ps2_keycode_rx_if.master  bus
);

  logic                 fall;
  logic                 data_bit;

  frame_state_t         state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BYTE_W-1:0]    shift;
  logic                 parity_bit;
  logic                 ext_flag;
  logic                 brk_flag;

  logic [BYTE_W-1:0]    code_q;
  logic                 ext_q;
  logic                 valid_q;
  logic                 break_q;
  logic                 perr_q;

  ps2_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .ps2_fall  (fall),
    .data_sync (data_bit)
  );

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  assign timeout_hit = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Frame FSM and byte decoder; the pulses default low so each lasts one cycle.
  always_ff @(posedge clk) begin
    valid_q <= 1'b0;
    break_q <= 1'b0;
    perr_q  <= 1'b0;
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      code_q     <= '0;
      ext_q      <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
`ifdef PS2_TIMEOUT_EN
      if (state == IDLE || fall) begin
        to_cnt <= '0;
      end else if (!timeout_hit) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
`endif
      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_bit) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {data_bit, shift[BYTE_W-1:1]};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_bit <= data_bit;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!frame_ok(shift, parity_bit, data_bit)) begin
              perr_q   <= 1'b1;
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end else if (shift == PS2_EXT) begin
              ext_flag <= 1'b1;
            end else if (shift == PS2_BRK) begin
              brk_flag <= 1'b1;
            end else begin
              // Release only clears the level if it names the key currently held.
              if (brk_flag) begin
                break_q <= 1'b1;
                if (shift == code_q && ext_flag == ext_q) begin
                  code_q <= '0;
                  ext_q  <= 1'b0;
                end
              end else begin
                valid_q <= 1'b1;
                code_q  <= shift;
                ext_q   <= ext_flag;
              end
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
`ifdef PS2_TIMEOUT_EN
      end else if (timeout_hit) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        shift    <= '0;
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
`endif
      end
    end
  end

  assign bus.key_code   = code_q;
  assign bus.key_ext    = ext_q;
  assign bus.key_valid  = valid_q;
  assign bus.key_break  = break_q;
  assign bus.parity_err = perr_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx with a byte-level keyboard model and per-cycle output compare.
`timescale 1ns/1ps
module tb_ps2_keycode_rx;
  import ps2_pkg::*;

  localparam int unsigned TB_TIMEOUT = 200;
  localparam int unsigned HALF       = 10;
  localparam logic [1:0]  EV_VALID   = 2'd1;
  localparam logic [1:0]  EV_BRK     = 2'd2;
  localparam logic [1:0]  EV_ERR     = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] code;
    logic       ext;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ps2_keycode_rx_if bus ();

  ps2_keycode_rx #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  bit   chk_en  = 1'b0;
  bit   quiet   = 1'b1;
  bit   saw_5a  = 1'b0;
  int   n_valid = 0;
  int   n_brk   = 0;
  int   n_err   = 0;
  logic [7:0] m_code = 8'h00;
  logic m_ext = 1'b0;
  logic m_pe  = 1'b0;
  logic m_pb  = 1'b0;
  ev_t  exp_q[$];
  ev_t  got;
  ev_t  want;
  int   np;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(act == exp, name, act, exp);
  endtask

  // Keyboard-level model: what one received byte means for the held key and the pulses.
  task automatic model_frame(input logic [7:0] d, input bit good);
    if (!good) begin
      exp_q.push_back('{EV_ERR, m_code, m_ext});
      m_pe = 1'b0;
      m_pb = 1'b0;
    end else if (d == 8'hE0) begin
      m_pe = 1'b1;
    end else if (d == 8'hF0) begin
      m_pb = 1'b1;
    end else begin
      if (m_pb) begin
        if (d == m_code && m_pe == m_ext) begin
          m_code = 8'h00;
          m_ext  = 1'b0;
        end
        exp_q.push_back('{EV_BRK, m_code, m_ext});
      end else begin
        m_code = d;
        m_ext  = m_pe;
        exp_q.push_back('{EV_VALID, m_code, m_ext});
      end
      m_pe = 1'b0;
      m_pb = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_code = 8'h00;
    m_ext  = 1'b0;
    m_pe   = 1'b0;
    m_pb   = 1'b0;
    exp_q.delete();
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] d, input logic par, input logic stop);
    quiet = 1'b0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stop);
    bus.ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    quiet = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok);
    logic par;
    par = par_ok ? ~(^d) : (^d);
    model_frame(d, par_ok && stop_ok);
    send_raw(d, par, stop_ok);
  endtask

  // Per-cycle compare: every pulse must match the next expected event; quiet levels match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      n_valid += int'(bus.key_valid);
      n_brk   += int'(bus.key_break);
      n_err   += int'(bus.parity_err);
      if (bus.key_valid && bus.key_code == 8'h5A) saw_5a = 1'b1;
    end
    if (chk_en && rst_n) begin
      np = int'(bus.key_valid) + int'(bus.key_break) + int'(bus.parity_err);
      if (np != 0) begin
        check_eq("pulse_exclusive", np, 1);
        got.kind = bus.key_valid ? EV_VALID : (bus.key_break ? EV_BRK : EV_ERR);
        got.code = bus.key_code;
        got.ext  = bus.key_ext;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_pulse", 32'(got), 32'h0);
        end else begin
          want = exp_q.pop_front();
          check_eq("event", 32'(got), 32'(want));
        end
      end else if (quiet) begin
        check_eq("level", {23'h0, bus.key_ext, bus.key_code}, {23'h0, m_ext, m_code});
      end
    end
  end

  initial begin
    logic [7:0] b5a;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("reset_key_code", bus.key_code, 8'h00);
    check_eq("reset_pulses", {bus.key_ext, bus.key_valid, bus.key_break, bus.parity_err}, 4'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);

    // Single make code.
    send_frame(KEY_1, 1'b1, 1'b1);
    check_eq("make_16_code", bus.key_code, 8'h16);
    check_eq("make_16_ext", bus.key_ext, 1'b0);

    // Break of a different key holds; break of the held key clears.
    send_frame(KEY_2, 1'b1, 1'b1);
    check_eq("make_1e_code", bus.key_code, 8'h1E);
    send_frame(PS2_BRK, 1'b1, 1'b1);
    send_frame(KEY_1, 1'b1, 1'b1);
    check_eq("break_other_holds", bus.key_code, 8'h1E);
    send_frame(PS2_BRK, 1'b1, 1'b1);
    send_frame(KEY_2, 1'b1, 1'b1);
    check_eq("break_1e_clears", bus.key_code, 8'h00);

    // Extended make then extended break.
    send_frame(PS2_EXT, 1'b1, 1'b1);
    send_frame(KEY_UP, 1'b1, 1'b1);
    check_eq("ext_make_code", bus.key_code, 8'h75);
    check_eq("ext_make_ext", bus.key_ext, 1'b1);
    send_frame(PS2_EXT, 1'b1, 1'b1);
    send_frame(PS2_BRK, 1'b1, 1'b1);
    send_frame(KEY_UP, 1'b1, 1'b1);
    check_eq("ext_break_code", bus.key_code, 8'h00);
    check_eq("ext_break_ext", bus.key_ext, 1'b0);

    // Frame errors, then a good frame.
    send_frame(KEY_ESC, 1'b0, 1'b1);
    check_eq("bad_parity_holds", bus.key_code, 8'h00);
    send_frame(KEY_ENTER, 1'b1, 1'b0);
    check_eq("bad_stop_holds", bus.key_code, 8'h00);
    send_frame(KEY_ESC, 1'b1, 1'b1);
    check_eq("good_after_err", bus.key_code, 8'h76);

    check_eq("count_valid", n_valid, 4);
    check_eq("count_break", n_brk, 3);
    check_eq("count_perr", n_err, 2);

    // Reset after the third data bit of a frame.
    quiet = 1'b0;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_eq("midreset_outputs",
             {bus.key_code, bus.key_ext, bus.key_valid, bus.key_break, bus.parity_err}, 12'h000);
    quiet = 1'b1;
    send_frame(KEY_2, 1'b1, 1'b1);
    check_eq("after_midreset_code", bus.key_code, 8'h1E);
    check_eq("events_consumed", exp_q.size(), 0);

    // Truncated frame, long idle, then a full 0x5A frame.
    chk_en = 1'b0;
    saw_5a = 1'b0;
    quiet  = 1'b0;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TB_TIMEOUT + 10) @(negedge clk);
    b5a = KEY_ENTER;
    send_raw(b5a, ~(^b5a), 1'b1);
    repeat (5) @(negedge clk);
`ifdef PS2_TIMEOUT_EN
    check_eq("timeout_recovers_valid", saw_5a, 1'b1);
    check_eq("timeout_recovers_code", bus.key_code, 8'h5A);
`else
    check(!saw_5a, "no_timeout_no_5a_pulse", saw_5a, 1'b0);
    check(bus.key_code != 8'h5A, "no_timeout_no_5a_code", bus.key_code, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_keycode_rx.md
# ps2_keycode_rx

Receives PS/2 keyboard frames and produces the 8-bit scan code that the mode controller and board-move logic consume as `ModeKey`. It decodes the `0xE0` extended prefix and the `0xF0` break prefix, holds the last pressed key as a level, and flags releases, new presses and frame errors with single-cycle pulses. It sits between the board's PS/2 pins and every game block that compares against key codes such as `0x16`, `0x1E`, `0x76` and `0x5A`.

## Interface
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles of `ps2_clk` inactivity mid-frame before the frame is abandoned (1 ms at 50 MHz). Used only with `PS2_TIMEOUT_EN`.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  synchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `key_code`  out  8  code of the last pressed key. Drops to `0x00` when that key is released. Reset `0x00`.
- `key_ext`  out  1  set when `key_code` was preceded by `0xE0`. Reset 0.
- `key_valid`  out  1  one-cycle pulse on each accepted make code, including typematic repeats. Reset 0.
- `key_break`  out  1  one-cycle pulse on each accepted break code. Reset 0.
- `parity_err`  out  1  one-cycle pulse when a frame fails the parity or stop-bit check. Reset 0.

## Operation
- **Input synchronisation:** `ps2_clk` and `ps2_data` each pass through 2 flip-flops. A third flop on the clock path provides edge detection. A falling edge is detected when the synced clock is 0 and the delayed clock is 1, and the synced data is sampled in that cycle.
- **Frame FSM** (advances only on detected falling edges):
  - `IDLE`: sampled data 0 (start bit) goes to `DATA` with the bit count cleared. Sampled data 1 stays in `IDLE` and is treated as a glitch.
  - `DATA`: shift the sampled bit in LSB first. After the 8th bit, go to `PARITY`.
  - `PARITY`: store the parity bit, then go to `STOP`.
  - `STOP`: the frame is accepted only if the stop bit is 1 and the 8 data bits plus the parity bit contain an odd number of ones.
    - If rejected: pulse `parity_err`, clear the ext and brk prefix flags, leave all key outputs unchanged.
    - In both cases, return to `IDLE`.
- **Accepted byte handling:**
  - `0xE0`: set the ext flag. No output pulse.
  - `0xF0`: set the brk flag. No output pulse.
  - Any other byte with brk set: pulse `key_break`. If the byte equals `key_code` and the ext flag equals `key_ext`, clear `key_code` to `0x00` and `key_ext` to 0. Otherwise the key outputs hold.
  - Any other byte with brk clear: load `key_code` with the byte, load `key_ext` with the ext flag, and pulse `key_valid`.
  - Both prefix flags clear after any non-prefix byte.
- **Simultaneous events:** a falling edge in the same cycle as `rst_n` = 0 is ignored, and reset wins.
- **Reset mid-frame:** the FSM returns to `IDLE` and the partial byte is discarded. The next start bit begins a fresh frame.

## Timing
- The falling edge of raw `ps2_clk` is detected 2–3 `clk` cycles after it occurs, because of synchroniser latency.
- For the stop bit detected in cycle k, `key_code`, `key_ext` and the pulses are visible in cycle k+1.
- Every pulse is exactly 1 cycle wide.
- At most one of `key_valid`, `key_break` or `parity_err` is asserted per frame.
- `key_code` is a registered level. It stays stable between accepted frames, so consumers may sample it on any `clk` edge.

## Configuration
- Macro: `PS2_TIMEOUT_EN`.
- **Defined:** a counter runs while the FSM is outside `IDLE` and reloads to 0 on every detected falling edge. When the counter reaches `TIMEOUT_CYCLES`:
  - the FSM goes to `IDLE`,
  - the partial byte and both prefix flags are discarded,
  - no error pulse is raised.
- **Undefined:** there is no counter. A truncated frame stays partially received until enough later edges arrive to complete it.

## Structure
- **Package `ps2_pkg`:**
  - frame-state enum: `IDLE`, `DATA`, `PARITY`, `STOP`.
  - prefix constants `PS2_EXT` = `0xE0` and `PS2_BRK` = `0xF0`.
  - shared key constants: `KEY_1` = `0x16`, `KEY_2` = `0x1E`, `KEY_ESC` = `0x76`, `KEY_ENTER` = `0x5A`, `KEY_UP` = `0x75`, `KEY_DOWN` = `0x72`, `KEY_LEFT` = `0x6B`, `KEY_RIGHT` = `0x74`. All game blocks use these constants.
- **Sub-module `ps2_sync`:** the 2-flop synchronisers plus the falling-edge detector. It outputs `ps2_fall` and the synced data. It is also reusable for a future PS/2 host transmitter.

## Test plan
- **Single make code:** frame `0x16` with parity 0 and stop 1 → `key_code` = `0x16`, `key_ext` = 0, one `key_valid` pulse, no other pulses.
- **Break sequence:** make `0x1E`, then `0xF0`, then `0x1E` → `key_code` becomes `0x1E`, then returns to `0x00`, with exactly one `key_break` pulse. Break `0xF0`, `0x16` while `key_code` = `0x1E` → `key_break` pulses and `key_code` stays `0x1E`.
- **Extended code:** `0xE0`, `0x75` → `key_code` = `0x75`, `key_ext` = 1, one `key_valid` pulse. Then `0xE0`, `0xF0`, `0x75` → `key_code` = `0x00`, `key_ext` = 0.
- **Frame errors:**
  - `0x76` sent with wrong parity → `parity_err` pulses once and `key_code` is unchanged.
  - `0x5A` sent with stop bit 0 → `parity_err` pulses once.
  - A following good `0x76` → `key_code` = `0x76`.
- **Timeout:** start bit plus 4 data bits, then idle for `TIMEOUT_CYCLES` + 10 cycles, then a full `0x5A` frame.
  - With `PS2_TIMEOUT_EN`: `key_code` = `0x5A`.
  - Without it: the output is garbled or absent, and the bench checks that no `0x5A` result appears.
- **Reset mid-frame:** assert `rst_n` = 0 for 1 cycle after the 3rd data bit of a frame → all outputs are 0. The next complete `0x1E` frame decodes to `key_code` = `0x1E`.
